booth_radix4_seq_ctrl: RTL and testbench

//  Sequencer for a radix-4 Booth multiplier built around the 3-bit Booth recoder.
//  - Latches a signed multiplicand/multiplier pair on a start handshake.
//  - Presents one multiplier triplet per cycle to the external recoder and consumes its recoded digit.
//  - Accumulates the shifted partial products and reports the signed 2*WIDTH product with a done pulse.

---
 rtl/booth_radix4_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_booth_radix4_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_ctrl.sv
// Radix-4 Booth multiplier sequencer driving an external 3-bit recoder.
// Optional macro BOOTH_RECODE_CHECK_EN adds the recode_err output.
module booth_radix4_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2:0]           mul_triplet,
    input  logic [2:0]           recoded_data,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
`ifdef BOOTH_RECODE_CHECK_EN
    ,
    output logic                 recode_err
`endif
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic signed [AW-1:0]  r_acc;
    logic [CW-1:0]         r_count;
    logic                  r_ready;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_product;

    logic [WIDTH:0]        w_bext;
    logic [CW:0]           w_shamt;
    logic [2:0]            w_trip;
    logic signed [AW-1:0]  w_a_ext;
    logic signed [AW-1:0]  w_pp;
    logic signed [AW-1:0]  w_pp_sh;
    logic signed [AW-1:0]  w_acc_nxt;

    // Multiplier with implicit B[-1]=0 appended; triplet i starts at bit 2i.
    assign w_bext  = {r_b, 1'b0};
    assign w_shamt = {r_count, 1'b0};
    assign w_trip  = w_bext[w_shamt +: 3];
    assign w_a_ext = {{(AW-WIDTH){r_a[WIDTH-1]}}, r_a};

    // Decode the recoder digit into a partial product; unknown codes add zero.
    always_comb begin
        w_pp = '0;
        case (recoded_data)
            3'b001:  w_pp = w_a_ext;
            3'b010:  w_pp = w_a_ext <<< 1;
            3'b101:  w_pp = -w_a_ext;
            3'b110:  w_pp = -(w_a_ext <<< 1);
            default: w_pp = '0;
        endcase
    end

    assign w_pp_sh   = w_pp <<< w_shamt;
    assign w_acc_nxt = r_acc + w_pp_sh;

`ifdef BOOTH_RECODE_CHECK_EN
    logic r_err;
    logic w_illegal;

    // Flag any code outside the five legal digits, including X.
    always_comb begin
        w_illegal = 1'b1;
        case (recoded_data)
            3'b000, 3'b001, 3'b010,
            3'b101, 3'b110: w_illegal = 1'b0;
            default:        w_illegal = 1'b1;
        endcase
    end

    // Sticky error for the operation in flight, cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= 1'b0;
        end else if (r_state == S_RUN && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign recode_err = r_err;
`endif

    // Control FSM: accept, iterate N digits, pulse done, return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= multiplicand;
                        r_b     <= multiplier;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    if (r_count == CW'(N - 1)) begin
                        r_count   <= '0;
                        r_product <= w_acc_nxt[2*WIDTH-1:0];
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign product     = r_product;
    assign mul_triplet = (r_state == S_RUN) ? w_trip : 3'b000;

endmodule

// File: tb/tb_booth_radix4_seq_ctrl.sv
// Directed bench for booth_radix4_seq_ctrl with a behavioural recoder.
// Exercises BOOTH_RECODE_CHECK_EN checks when that macro is defined.
module tb_booth_radix4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  trip;
    logic [2:0]  rec;
    logic [15:0] prod;
    logic        done;
    logic        force_bad = 1'b0;
`ifdef BOOTH_RECODE_CHECK_EN
    logic        rerr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_radix4_seq_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .multiplicand (a),
        .multiplier   (b),
        .mul_triplet  (trip),
        .recoded_data (rec),
        .product      (prod),
        .done         (done)
`ifdef BOOTH_RECODE_CHECK_EN
        ,
        .recode_err   (rerr)
`endif
    );

    // Standard radix-4 Booth recoder, with an override for bad codes.
    always_comb begin
        rec = 3'b000;
        case (trip)
            3'b001, 3'b010: rec = 3'b001;
            3'b011:         rec = 3'b010;
            3'b100:         rec = 3'b110;
            3'b101, 3'b110: rec = 3'b101;
            default:        rec = 3'b000;
        endcase
        if (force_bad) rec = 3'b111;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [7:0] ia,
                         input logic [7:0] ib, input logic [15:0] exp);
        int n;
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_prod"}, prod, exp);
        tick();
        chk({tag, "_rdy"}, ready, 1);
    endtask

    initial begin
        int nd;
        int n;
        int d1;
        int d2;
        logic [15:0] p1;
        logic [15:0] p2;

        // reset state
        tick();
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_prod", prod, 0);
        chk("rst_trip", trip, 0);
        rst = 1'b0;
        tick();

        // 7*3 with exact latency and busy window
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("t1_busy", ready, 0);
            chk("t1_done", done, 32'(c == 5));
            if (c < 5) tick();
        end
        chk("t1_prod", prod, 16'd21);
        tick();
        chk("t1_rdy", ready, 1);
        chk("t1_done_lo", done, 0);

        // corner operands
        do_op("t2_mm", 8'h80, 8'h80, 16'h4000);
        do_op("t2_mp", 8'h80, 8'h7F, 16'hC080);
        do_op("t2_zm", 8'h00, 8'hFF, 16'h0000);
        do_op("t2_pp", 8'h7F, 8'h7F, 16'h3F01);
        do_op("t2_nn", 8'hFF, 8'hFF, 16'h0001);

        // start during RUN is ignored
        a = 8'hFD;
        b = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'd5;
        b = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                nd++;
                chk("t3_prod", prod, 16'hFFDF);
            end
            tick();
        end
        chk("t3_ndone", nd, 1);
        chk("t3_hold", prod, 16'hFFDF);

        // reset mid-operation
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t4_trip1", trip, 3'b001);
        tick();
        rst = 1'b1;
        tick();
        chk("t4_ready", ready, 1);
        chk("t4_done", done, 0);
        chk("t4_prod", prod, 0);
        chk("t4_trip", trip, 0);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) nd++;
            tick();
        end
        chk("t4_nodone", nd, 0);
        do_op("t4_new", 8'd7, 8'd3, 16'd21);

        // back-to-back with start held
        d1 = -1;
        d2 = -1;
        p1 = '0;
        p2 = '0;
        a = 8'd3;
        b = 8'hFB;
        start = 1'b1;
        tick();
        a = 8'hFA;
        b = 8'd9;
        n = 1;
        while (n <= 14) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    p1 = prod;
                end else begin
                    d2 = n;
                    p2 = prod;
                end
            end
            if (n == 7) start = 1'b0;
            tick();
            n++;
        end
        chk("t5_d1", d1, 5);
        chk("t5_gap", d2 - d1, 6);
        chk("t5_p1", p1, 16'hFFF1);
        chk("t5_p2", p2, 16'hFFCA);

`ifdef BOOTH_RECODE_CHECK_EN
        // illegal digit at iteration 1 drops the +4A term of 7*3
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_err0", rerr, 0);
        tick();
        force_bad = 1'b1;
        tick();
        force_bad = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("t6_lat", n, 5);
        chk("t6_err", rerr, 1);
        chk("t6_prod", prod, 16'hFFF9);
        tick();
        a = 8'd2;
        b = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_clr", rerr, 0);
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("t6_prod2", prod, 16'd4);
        chk("t6_err2", rerr, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
